// File: rtl/uart_fifo_ahb.sv
// AHB-lite UART: runtime divisor, 5..8 data bits, optional parity, TX/RX FIFOs, sticky flags, level irqs.
// Zero-wait-state slave; a push into a full FIFO is dropped and raises the matching sticky flag.

module uart_fifo_ahb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

module uart_fifo_ahb #(
  parameter int WORD_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int DATA_BITS   = 8,
  parameter int DEFAULT_DIV = 434
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  HSELx,
  input  logic [WORD_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [1:0]            HTRANS,
  input  logic [WORD_WIDTH-1:0] HWDATA,
  output logic [WORD_WIDTH-1:0] HRDATA,
  output logic                  HREADY,
  output logic [1:0]            HRESP,
  input  logic                  RX,
  output logic                  TX,
  output logic                  irq_tx,
  output logic                  irq_rx
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic       acc_vld_q, acc_wr_q;
  logic [1:0] acc_addr_q;
  logic       wr_data, wr_status, wr_ctrl, wr_div, rd_data;
  logic [3:0] ctrl_q;
  logic [15:0] div_q;
  logic       rx_ovr_q, par_err_q, frm_err_q, tx_ovf_q;
  logic       rx_ovr_d, par_err_d, frm_err_d, tx_ovf_d;
  logic       irq_tx_q, irq_rx_q;
  logic [8:0] status;

  logic                 tx_full, tx_empty, tx_pop;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_full, rx_empty;
  logic [DATA_BITS-1:0] rx_head;

  logic unused_bits;
  assign unused_bits = ^{HSIZE, HADDR[WORD_WIDTH-1:4], HADDR[1:0], HWDATA[WORD_WIDTH-1:16]};

  assign HREADY = 1'b1;
  assign HRESP  = 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_vld_q  <= 1'b0;
      acc_wr_q   <= 1'b0;
      acc_addr_q <= 2'd0;
    end else begin
      acc_vld_q  <= HSELx && HTRANS[1];
      acc_wr_q   <= HWRITE;
      acc_addr_q <= HADDR[3:2];
    end
  end

  assign wr_data   = acc_vld_q && acc_wr_q && (acc_addr_q == 2'd0);
  assign wr_status = acc_vld_q && acc_wr_q && (acc_addr_q == 2'd1);
  assign wr_ctrl   = acc_vld_q && acc_wr_q && (acc_addr_q == 2'd2);
  assign wr_div    = acc_vld_q && acc_wr_q && (acc_addr_q == 2'd3);
  assign rd_data   = acc_vld_q && !acc_wr_q && (acc_addr_q == 2'd0);

  // TX state machine
  logic [2:0]           tx_state_q, tx_state_d;
  logic [15:0]          tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic                 tx_par_q, tx_par_d, tx_paren_q, tx_paren_d;
  logic                 tx_q, tx_d, tx_last, tx_busy;

  assign tx_busy = (tx_state_q != S_IDLE);
  assign TX      = tx_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_par_d   = tx_par_q;
    tx_paren_d = tx_paren_q;
    tx_pop     = 1'b0;
    tx_last    = (tx_cnt_q == tx_div_q - 16'd1);
    if (tx_state_q != S_IDLE) tx_cnt_d = tx_last ? 16'd0 : tx_cnt_q + 16'd1;
    case (tx_state_q)
      S_IDLE:  ;
      S_START: if (tx_last) begin
        tx_state_d = S_DATA;
        tx_bit_d   = 3'd0;
      end
      S_DATA: if (tx_last) begin
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = tx_bit_q + 3'd1;
        if (tx_bit_q == LAST_BIT) tx_state_d = tx_paren_q ? S_PARITY : S_STOP;
      end
      S_PARITY: if (tx_last) tx_state_d = S_STOP;
      S_STOP:   if (tx_last) tx_state_d = S_IDLE;
      default:  tx_state_d = S_IDLE;
    endcase
    // Frame start (from idle or straight out of a stop bit) latches divisor and parity mode.
    if (!tx_empty && (tx_state_q == S_IDLE || (tx_state_q == S_STOP && tx_last))) begin
      tx_pop     = 1'b1;
      tx_state_d = S_START;
      tx_cnt_d   = 16'd0;
      tx_shift_d = tx_head;
      tx_div_d   = div_q;
      tx_paren_d = ctrl_q[0];
      tx_par_d   = (^tx_head) ^ ctrl_q[1];
    end
    case (tx_state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = tx_shift_d[0];
      S_PARITY: tx_d = tx_par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_div_q   <= 16'(DEFAULT_DIV);
      tx_shift_q <= '0;
      tx_bit_q   <= 3'd0;
      tx_par_q   <= 1'b0;
      tx_paren_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_par_q   <= tx_par_d;
      tx_paren_q <= tx_paren_d;
      tx_q       <= tx_d;
    end
  end

  // RX path: two-flop synchronizer plus one more stage for falling-edge detection
  logic                 rx_s1_q, rx_s2_q, rx_s3_q;
  logic [2:0]           rx_state_q, rx_state_d;
  logic [15:0]          rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic                 rx_paren_q, rx_paren_d, rx_parodd_q, rx_parodd_d;
  logic                 rx_push_q, rx_push_d, rx_last, par_set, frm_set;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + 16'd1;
    rx_div_d    = rx_div_q;
    rx_shift_d  = rx_shift_q;
    rx_bit_d    = rx_bit_q;
    rx_paren_d  = rx_paren_q;
    rx_parodd_d = rx_parodd_q;
    rx_push_d   = 1'b0;
    par_set     = 1'b0;
    frm_set     = 1'b0;
    rx_last     = (rx_cnt_q == rx_div_q - 16'd1);
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = 16'd0;
        if (rx_s3_q && !rx_s2_q) begin
          rx_state_d  = S_START;
          rx_div_d    = div_q;
          rx_paren_d  = ctrl_q[0];
          rx_parodd_d = ctrl_q[1];
        end
      end
      S_START: if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
        rx_cnt_d   = 16'd0;
        rx_bit_d   = 3'd0;
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_last) begin
        rx_cnt_d   = 16'd0;
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == LAST_BIT) rx_state_d = rx_paren_q ? S_PARITY : S_STOP;
      end
      S_PARITY: if (rx_last) begin
        rx_cnt_d   = 16'd0;
        par_set    = (rx_s2_q != ((^rx_shift_q) ^ rx_parodd_q));
        rx_state_d = S_STOP;
      end
      S_STOP: if (rx_last) begin
        rx_state_d = S_IDLE;
        rx_push_d  = rx_s2_q;
        frm_set    = !rx_s2_q;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= 16'd0;
      rx_div_q    <= 16'(DEFAULT_DIV);
      rx_shift_q  <= '0;
      rx_bit_q    <= 3'd0;
      rx_paren_q  <= 1'b0;
      rx_parodd_q <= 1'b0;
      rx_push_q   <= 1'b0;
    end else begin
      rx_s1_q     <= RX;
      rx_s2_q     <= rx_s1_q;
      rx_s3_q     <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_div_q    <= rx_div_d;
      rx_shift_q  <= rx_shift_d;
      rx_bit_q    <= rx_bit_d;
      rx_paren_q  <= rx_paren_d;
      rx_parodd_q <= rx_parodd_d;
      rx_push_q   <= rx_push_d;
    end
  end

  uart_fifo_ahb_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push_i(wr_data), .push_dat_i(HWDATA[DATA_BITS-1:0]), .pop_i(tx_pop),
    .head_dat_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );

  uart_fifo_ahb_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push_i(rx_push_q), .push_dat_i(rx_shift_q), .pop_i(rd_data),
    .head_dat_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );

  // Sticky flags: a same-cycle set overrides a write-1-to-clear.
  always_comb begin
    rx_ovr_d  = (rx_ovr_q  && !(wr_status && HWDATA[5])) || (rx_push_q && rx_full);
    par_err_d = (par_err_q && !(wr_status && HWDATA[6])) || par_set;
    frm_err_d = (frm_err_q && !(wr_status && HWDATA[7])) || frm_set;
    tx_ovf_d  = (tx_ovf_q  && !(wr_status && HWDATA[8])) || (wr_data && tx_full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= 4'd0;
      div_q     <= 16'(DEFAULT_DIV);
      rx_ovr_q  <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      tx_ovf_q  <= 1'b0;
      irq_tx_q  <= 1'b0;
      irq_rx_q  <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= HWDATA[3:0];
      if (wr_div)  div_q  <= (HWDATA[15:0] < 16'd16) ? 16'd16 : HWDATA[15:0];
      rx_ovr_q  <= rx_ovr_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      tx_ovf_q  <= tx_ovf_d;
      irq_tx_q  <= ctrl_q[2] && tx_empty && !tx_busy;
      irq_rx_q  <= ctrl_q[3] && (!rx_empty || par_err_q || frm_err_q || rx_ovr_q);
    end
  end

  assign irq_tx = irq_tx_q;
  assign irq_rx = irq_rx_q;
  assign status = {tx_ovf_q, frm_err_q, par_err_q, rx_ovr_q, tx_busy,
                   rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    HRDATA = '0;
    if (acc_vld_q && !acc_wr_q) begin
      case (acc_addr_q)
        2'd0:    if (!rx_empty) HRDATA[DATA_BITS-1:0] = rx_head;
        2'd1:    HRDATA[8:0]  = status;
        2'd2:    HRDATA[3:0]  = ctrl_q;
        default: HRDATA[15:0] = div_q;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_fifo_ahb.sv
// Scoreboard bench for uart_fifo_ahb: AHB reads and TX frames are checked by monitors against queued expectations.
module tb_uart_fifo_ahb;
  localparam int CLK_P = 10;
  localparam int BIT_T = 16;
  localparam int DEPTH = 8;

  logic        clk, rst_n, HSELx, HWRITE, HREADY, TX, irq_tx, irq_rx;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS, HRESP;
  logic        rx_drv, loop_en, rx_line;

  assign rx_line = loop_en ? TX : rx_drv;

  uart_fifo_ahb dut (
    .clk(clk), .rst_n(rst_n), .HSELx(HSELx), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP), .RX(rx_line), .TX(TX),
    .irq_tx(irq_tx), .irq_rx(irq_rx)
  );

  initial begin
    clk = 1'b0;
    forever #(CLK_P/2) clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int frames_done = 0;
  time t_end = 0;

  // Expectation queues
  logic [31:0] rd_exp_q[$];
  logic [31:0] rd_mask_q[$];
  string       rd_name_q[$];
  logic [7:0]  txq_dat[$];
  logic        txq_pe[$];
  logic        txq_pb[$];

  // Reference model of the RX FIFO and sticky flags
  logic [7:0] m_rx[$];
  logic       m_ovr = 0, m_par = 0, m_frm = 0, m_txovf = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    logic [31:0] s;
    s = 32'h2;  // TX idle and empty
    if (m_rx.size() == DEPTH) s[2] = 1'b1;
    if (m_rx.size() == 0)     s[3] = 1'b1;
    s[5] = m_ovr; s[6] = m_par; s[7] = m_frm; s[8] = m_txovf;
    return s;
  endfunction

  task automatic model_rx_push(input logic [7:0] b);
    if (m_rx.size() == DEPTH) m_ovr = 1'b1;
    else m_rx.push_back(b);
  endtask

  task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    HSELx = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, a};
    @(negedge clk);
    HSELx = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
  endtask

  task automatic ahb_read(input logic [3:0] a, input logic [31:0] exp, input logic [31:0] mask,
                          input string nm);
    @(negedge clk);
    HSELx = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, a};
    rd_exp_q.push_back(exp); rd_mask_q.push_back(mask); rd_name_q.push_back(nm);
    @(negedge clk);
    HSELx = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic read_data(input string nm);
    logic [31:0] e;
    e = 32'h0;
    if (m_rx.size() != 0) e = {24'h0, m_rx.pop_front()};
    ahb_read(4'h0, e, 32'hFFFF_FFFF, nm);
  endtask

  task automatic clear_flags(input logic [31:0] w);
    ahb_write(4'h4, w);
    if (w[5]) m_ovr = 1'b0;
    if (w[6]) m_par = 1'b0;
    if (w[7]) m_frm = 1'b0;
    if (w[8]) m_txovf = 1'b0;
  endtask

  task automatic expect_tx(input logic [7:0] b, input logic pe, input logic po);
    txq_dat.push_back(b); txq_pe.push_back(pe); txq_pb.push_back((^b) ^ po);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (frames_done < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("frame_wait", frames_done, n);
  endtask

  task automatic drive_bit(input logic v);
    @(negedge clk);
    rx_drv = v;
    repeat (BIT_T - 1) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic pe, input logic po, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (pe) drive_bit((^b) ^ po);
    drive_bit(stop);
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (6) @(negedge clk);
    if (stop) model_rx_push(b);
    else m_frm = 1'b1;
  endtask

  // Read monitor: a read address phase seen at a rising edge is checked in its data phase.
  initial begin
    logic [31:0] e, m;
    string nm;
    forever begin
      @(posedge clk);
      if (HSELx && HTRANS[1] && !HWRITE) begin
        @(negedge clk);
        if (rd_exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rd_unexpected: got 0x%0h with no expectation queued", HRDATA);
        end else begin
          e = rd_exp_q.pop_front(); m = rd_mask_q.pop_front(); nm = rd_name_q.pop_front();
          check(nm, HRDATA & m, e & m);
        end
      end
    end
  end

  // TX monitor: decodes every frame on the line, checking each bit level on every cycle it is held.
  initial begin
    logic [7:0] d;
    logic pe, pb, eb, ab;
    int nb;
    forever begin
      @(negedge clk);
      if (rst_n && TX === 1'b0) begin
        if (txq_dat.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL tx_unexpected: start bit seen with no frame expected");
          repeat (10 * BIT_T - 1) @(negedge clk);
        end else begin
          d = txq_dat.pop_front(); pe = txq_pe.pop_front(); pb = txq_pb.pop_front();
          nb = pe ? 11 : 10;
          for (int b = 0; b < nb; b++) begin
            if (b == 0) eb = 1'b0;
            else if (b <= 8) eb = d[b-1];
            else if (pe && b == 9) eb = pb;
            else eb = 1'b1;
            ab = eb;
            for (int c = 0; c < BIT_T; c++) begin
              if (!(b == 0 && c == 0)) @(negedge clk);
              if (TX !== eb && ab === eb) ab = TX;
            end
            check($sformatf("tx_%02h_bit%0d", d, b), {31'h0, ab}, {31'h0, eb});
          end
          t_end = $time;
          frames_done++;
        end
      end
    end
  end

  initial begin
    #(50000 * CLK_P);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic pe, po;
    time t_rise;
    rst_n = 1'b0; HSELx = 1'b0; HADDR = 32'h0; HWRITE = 1'b0; HSIZE = 3'd2;
    HTRANS = 2'b00; HWDATA = 32'h0; rx_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'h0, TX}, 32'h1);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_irq", {30'h0, irq_tx, irq_rx}, 32'h0);
    check("hready_hresp", {29'h0, HREADY, HRESP}, 32'h4);
    rst_n = 1'b1;
    ahb_read(4'hC, 32'd434, 32'hFFFF_FFFF, "rst_div");
    ahb_read(4'h4, 32'h0A, 32'hFFFF_FFFF, "rst_status");
    ahb_read(4'h8, 32'h0, 32'hFFFF_FFFF, "rst_ctrl");
    read_data("rd_empty_after_rst");

    // Divisor clamp, then 16 cycles/bit for the rest of the run
    ahb_write(4'hC, 32'd5);
    ahb_read(4'hC, 32'd16, 32'hFFFF_FFFF, "div_clamp");
    ahb_write(4'hC, 32'd16);
    ahb_read(4'hC, 32'd16, 32'hFFFF_FFFF, "div_16");

    // Single frame, tx_ie on
    ahb_write(4'h8, 32'h4);
    expect_tx(8'hA5, 1'b0, 1'b0);
    ahb_write(4'h0, 32'hA5);
    repeat (50) @(negedge clk);
    check("irq_tx_busy", {31'h0, irq_tx}, 32'h0);
    wait_frames(1, 400);
    t_rise = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (irq_tx === 1'b1) begin
        t_rise = $time;
        break;
      end
    end
    check("irq_tx_lag", 32'(t_rise - t_end), 32'(2 * CLK_P));
    ahb_read(4'h4, status_exp(), 32'hFFFF_FFFF, "status_after_frame");

    // Pipelined burst of 10 writes: FIFO plus the frame already in flight absorb DEPTH+1
    ahb_write(4'h8, 32'h0);
    for (int k = 0; k < 10; k++) if (k < DEPTH + 1) expect_tx(8'h10 + 8'(k), 1'b0, 1'b0);
    m_txovf = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k < 10) begin
        HSELx = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
      end else begin
        HSELx = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
      end
      if (k > 0) HWDATA = 32'h10 + 32'(k - 1);
    end
    ahb_read(4'h4, 32'h111, 32'h111, "burst_full_ovf");
    clear_flags(32'h100);
    ahb_read(4'h4, 32'h0, 32'h100, "ovf_cleared");
    wait_frames(1 + DEPTH + 1, 12 * 10 * BIT_T);
    repeat (4) @(negedge clk);
    ahb_read(4'h4, status_exp(), 32'hFFFF_FFFF, "status_after_burst");

    // Loopback with odd parity
    loop_en = 1'b1;
    ahb_write(4'h8, 32'hB);
    expect_tx(8'h3C, 1'b1, 1'b1);
    ahb_write(4'h0, 32'h3C);
    wait_frames(DEPTH + 3, 400);
    repeat (6) @(negedge clk);
    model_rx_push(8'h3C);
    check("irq_rx_data", {31'h0, irq_rx}, 32'h1);
    ahb_read(4'h4, status_exp(), 32'hFFFF_FFFF, "status_rx_nonempty");
    read_data("loop_3c");
    ahb_read(4'h4, status_exp(), 32'hFFFF_FFFF, "status_rx_drained");

    // Randomized loopback frames with random parity mode
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255)); pe = 1'($urandom_range(0, 1)); po = 1'($urandom_range(0, 1));
      ahb_write(4'h8, {28'h0, 1'b1, 1'b0, po, pe});
      expect_tx(b, pe, po);
      ahb_write(4'h0, {24'h0, b});
      wait_frames(DEPTH + 4 + i, 400);
      repeat (6) @(negedge clk);
      model_rx_push(b);
      read_data($sformatf("loop_rand%0d", i));
    end
    loop_en = 1'b0;

    // Stop bit low: frame error, nothing pushed
    ahb_write(4'h8, 32'h8);
    send_rx(8'h55, 1'b0, 1'b0, 1'b0);
    ahb_read(4'h4, status_exp(), 32'hFFFF_FFFF, "status_frame_err");
    check("irq_rx_frm", {31'h0, irq_rx}, 32'h1);
    clear_flags(32'h80);
    ahb_read(4'h4, status_exp(), 32'hFFFF_FFFF, "frm_cleared");

    // Two-cycle glitch: false start
    @(negedge clk); rx_drv = 1'b0;
    repeat (2) @(negedge clk); rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    ahb_read(4'h4, status_exp(), 32'hFFFF_FFFF, "status_glitch");

    // Nine frames without reading: overrun on the last
    ahb_write(4'h8, 32'h0);
    for (int i = 0; i < DEPTH + 1; i++) send_rx(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1);
    ahb_read(4'h4, status_exp(), 32'hFFFF_FFFF, "status_overrun");
    for (int i = 0; i < DEPTH; i++) read_data($sformatf("rx_order%0d", i));
    read_data("rd_empty_no_pop");
    ahb_read(4'h4, status_exp(), 32'hFFFF_FFFF, "status_ovr_sticky");
    clear_flags(32'h20);
    ahb_read(4'h4, status_exp(), 32'hFFFF_FFFF, "ovr_cleared");

    repeat (4) @(negedge clk);
    check("tx_queue_drained", 32'(txq_dat.size()), 32'h0);
    check("rd_queue_drained", 32'(rd_exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
